// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM driving the ALU, PC, IR, register file and memory enables
module multicycle_control_unit #(
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  parameter logic [4:0] JAL_REG     = 5'd31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt_field,
  input  logic       zero_flag,
  output logic [2:0] state,
  output logic [4:0] alu_operation,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       mem_write,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  // reg_dst=10 selects the link register (JAL_REG) at the register file.
  localparam logic [1:0] REG_DST_LINK = (JAL_REG == 5'd31) ? 2'b10 : 2'b10;

  state_e state_q, state_d;

  logic [4:0] exe_op;
  logic       legal, is_rtype, uses_imm, is_ori, is_shift, is_muldiv;
  logic       is_branch, taken, is_lw, is_sw, is_j, is_jal, is_jr;

  // Instruction decode from the held IR fields: ALU code, class flags and legality.
  always_comb begin
    exe_op    = 5'b00000;
    legal     = 1'b0;
    is_rtype  = (opcode == 6'b000000);
    uses_imm  = 1'b0;
    is_ori    = 1'b0;
    is_shift  = 1'b0;
    is_muldiv = 1'b0;
    is_branch = 1'b0;
    taken     = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    if (is_rtype) begin
      legal = 1'b1;
      case (funct)
        6'b100000: exe_op = 5'b00001;
        6'b100001: exe_op = 5'b10101;
        6'b100010: exe_op = 5'b01000;
        6'b100100: exe_op = 5'b00010;
        6'b100101: exe_op = 5'b00100;
        6'b100110: exe_op = 5'b10110;
        6'b100111: exe_op = 5'b00011;
        6'b101010: exe_op = 5'b00101;
        6'b000000: begin exe_op = 5'b00110; is_shift = 1'b1; end
        6'b000010: begin exe_op = 5'b00111; is_shift = 1'b1; end
        6'b000011: begin exe_op = 5'b01101; is_shift = 1'b1; end
        6'b011000: begin exe_op = 5'b01100; is_muldiv = 1'b1; end
        6'b011010: begin exe_op = 5'b01001; is_muldiv = 1'b1; end
        6'b010000: exe_op = 5'b01010;
        6'b010010: exe_op = 5'b01011;
        6'b001000: is_jr = 1'b1;
        default:   legal = 1'b0;
      endcase
    end else begin
      legal = 1'b1;
      case (opcode)
        6'b001000: begin exe_op = 5'b01110; uses_imm = 1'b1; end
        6'b001010: begin exe_op = 5'b11010; uses_imm = 1'b1; end
        6'b001101: begin exe_op = 5'b11011; uses_imm = 1'b1; is_ori = 1'b1; end
        6'b100011: begin exe_op = 5'b10000; uses_imm = 1'b1; is_lw = 1'b1; end
        6'b101011: begin exe_op = 5'b10001; uses_imm = 1'b1; is_sw = 1'b1; end
        6'b000100: begin exe_op = 5'b11001; is_branch = 1'b1; taken = zero_flag; end
        6'b000101: begin exe_op = 5'b01111; is_branch = 1'b1; taken = !zero_flag; end
        6'b000001: begin
          is_branch = 1'b1;
          if (rt_field == 5'b00000) begin
            exe_op = 5'b10111;
            taken  = zero_flag;
          end else if (rt_field == 5'b00001) begin
            exe_op = 5'b11000;
            taken  = !zero_flag;
          end else begin
            legal = 1'b0;
          end
        end
        6'b000010: is_j = 1'b1;
        6'b000011: is_jal = 1'b1;
        default:   legal = (opcode == HALT_OPCODE);
      endcase
    end
  end

  // State register; reset returns to IF.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-state and per-state outputs; reset forces every output quiet.
  always_comb begin
    state_d       = state_q;
    alu_operation = 5'b00000;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    ext_sel       = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 1'b0;
    mem_write     = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (opcode == HALT_OPCODE) begin
          state_d = S_HALT;
        end else if (!legal) begin
          illegal = 1'b1;
          state_d = S_IF;
        end else if (is_j || is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'b10;
          reg_write = is_jal;
          reg_dst   = is_jal ? REG_DST_LINK : 2'b00;
          state_d   = S_IF;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          state_d  = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alu_operation = exe_op;
        alu_src_a     = is_shift;
        alu_src_b     = uses_imm;
        ext_sel       = uses_imm && !is_ori;
        if (is_branch) begin
          pc_write = taken;
          pc_src   = 2'b01;
          state_d  = S_IF;
        end else if (is_muldiv) begin
          state_d = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_write = is_sw;
        state_d   = is_sw ? S_IF : S_WB;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        reg_dst    = is_rtype ? 2'b01 : 2'b00;
        state_d    = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    if (rst) begin
      state_d       = S_IF;
      alu_operation = 5'b00000;
      alu_src_a     = 1'b0;
      alu_src_b     = 1'b0;
      ext_sel       = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 1'b0;
      mem_write     = 1'b0;
      halted        = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle MIPS control FSM sitting directly upstream of the ALU.
- Decodes the held instruction register fields and sequences IF/ID/EXE/MEM/WB.
- Drives alu_operation, alu_src_a and alu_src_b into the ALU, and the PC, IR, register-file and memory enables.
- Consumes zero_flag from the ALU to resolve branches.

Parameters:
HALT_OPCODE, 6'b111111, opcode that moves the FSM to HALT.
JAL_REG, 5'd31, link register index reported on reg_dst=2'b10 (documentation only, not decoded here).

Ports:
clk  in  1  system clock, rising-edge state updates.
rst  in  1  synchronous active-high reset.
opcode  in  6  IR[31:26], stable from ID until next IF.
funct  in  6  IR[5:0].
rt_field  in  5  IR[20:16], selects bltz (00000) or bgez (00001) under opcode 000001.
zero_flag  in  1  ALU zero flag, valid before the rising edge ending EXE.
state  out  3  IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
alu_operation  out  5  ALU op code; 00000 outside EXE.
alu_src_a  out  1  0=rs, 1=shift amount.
alu_src_b  out  1  0=rt, 1=immediate_extend.
ext_sel  out  1  1=sign-extend immediate, 0=zero-extend (ori only).
pc_write  out  1  PC load enable.
pc_src  out  2  00=PC+4, 01=branch target, 10=jump target, 11=rs.
ir_write  out  1  IR load enable.
reg_write  out  1  register-file write enable.
reg_dst  out  2  00=rt, 01=rd, 10=r31.
mem_to_reg  out  1  1=write-back data comes from memory.
mem_write  out  1  data memory write enable.
halted  out  1  high in HALT.
illegal  out  1  one-cycle pulse in ID on an undecodable instruction.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Only the state register is sequential. All other outputs are combinational from state, opcode, funct, rt_field and zero_flag.
- While rst=1: next state is IF. All enables (pc_write, ir_write, reg_write, mem_write), illegal and halted are forced to 0, and alu_operation=00000. This also applies when rst asserts mid-instruction; no partial write occurs.
- IF: ir_write=1, pc_write=1, pc_src=00; next state ID.
- ID decode:
  - j (000010): pc_write=1, pc_src=10; next IF.
  - jal (000011): as j, plus reg_write=1, reg_dst=10; next IF.
  - R-type jr (funct 001000): pc_write=1, pc_src=11; next IF.
  - HALT_OPCODE: next HALT.
  - Undecodable opcode/funct/rt_field: illegal=1, no enables; next IF.
  - All others: next EXE.
- EXE alu_operation map:
  - R-type (opcode 000000), by funct: add 100000→00001; addu 100001→10101; sub 100010→01000; and 100100→00010; or 100101→00100; xor 100110→10110; nor 100111→00011; slt 101010→00101; sll 000000→00110; srl 000010→00111; sra 000011→01101; mult 011000→01100; div 011010→01001; mfhi 010000→01010; mflo 010010→01011.
  - I-type, by opcode: addi 001000→01110; slti 001010→11010; ori 001101→11011; lw 100011→10000; sw 101011→10001; beq 000100→11001; bne 000101→01111; bltz 000001/rt 00000→10111; bgez 000001/rt 00001→11000.
- EXE operand selects: alu_src_a=1 only for sll/srl/sra. alu_src_b=1 for addi, slti, ori, lw, sw. ext_sel=0 only for ori.
- EXE next state:
  - Branches: pc_write = taken, pc_src=01; next IF. taken is zero_flag for beq and bltz, !zero_flag for bne and bgez.
  - mult, div: next IF (HI/LO are internal to the ALU; no writeback).
  - lw, sw: next MEM.
  - All other ALU ops: next WB.
- alu_operation holds its code for the whole EXE cycle and returns to 00000 on exit. 00000 makes the ALU retain computation_result through MEM/WB.
- MEM: sw asserts mem_write=1, next IF. lw asserts no enable, next WB.
- WB:
  - reg_write=1.
  - lw: mem_to_reg=1, reg_dst=00.
  - I-type ALU ops: reg_dst=00.
  - R-type: reg_dst=01.
  - Next IF.
- HALT: all enables 0, halted=1; remains in HALT until rst.
- Cycle counts: j/jal/jr/illegal 2; branch, mult, div 3; ALU op and sw 4; lw 5.
- Unused output fields are 0 in every state.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-EXE of add → state=000, all enables 0, alu_operation=00000. Then 1 cycle after release, ir_write=1 and pc_write=1.
- add (000000/100000): states IF,ID,EXE,WB → EXE alu_operation=00001, alu_src_a/b=0/0. WB reg_write=1, reg_dst=01. Back to IF after 4 cycles.
- lw (100011) then sw (101011): lw sequence IF,ID,EXE,MEM,WB with alu_operation=10000, alu_src_b=1, WB mem_to_reg=1. sw has mem_write=1 only in MEM and returns to IF after 4 cycles.
- Branches: beq with zero_flag=1 → pc_write=1, pc_src=01 in EXE. bne with zero_flag=1 → pc_write=0. bgez (000001, rt=00001) with zero_flag=0 → taken.
- Jumps: jal (000011) → in ID pc_write=1, pc_src=10, reg_write=1, reg_dst=10; IF next. jr → pc_src=11.
- opcode 010111 → illegal=1 for exactly 1 cycle in ID, then IF. HALT_OPCODE → halted=1 indefinitely with no enables; rst=1 returns state to 000.
